// File: rtl/display_bcd_driver.sv
// display_bcd_driver: signed binary to four 7-segment digits (sign, hundreds, tens, units) via double dabble.
// Latency: n+2 clk from the first IDLE cycle that sees a new value to the segment outputs updating.
// Backpressure: none; input changes during a conversion are ignored and the latest value is picked up afterwards.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   display     - signed n-bit value from the cpu
//   digits, ten_digits, hun_digits, sign - active-low segments {g,f,e,d,c,b,a}
//   busy        - high during LOAD and SHIFT
//   done        - one-cycle pulse in the cycle the segment outputs take their new pattern
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading-zero hundreds/tens digits.

module display_bcd_driver #(
   parameter int n = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [n-1:0] display,
   output logic [6:0]   digits,
   output logic [6:0]   ten_digits,
   output logic [6:0]   hun_digits,
   output logic [6:0]   sign,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(n + 1);
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t        state, state_nxt;
   logic [n-1:0]  last;
   logic [n-1:0]  mag;
   logic          neg;
   logic          force_cv;
   logic [11:0]   bcd;
   logic [CW-1:0] cnt;

   logic [11:0]   bcd_adj;
   logic [11:0]   bcd_sh;
   logic [n-1:0]  mag_sh;
   logic          last_shift;
   logic [6:0]    hun_seg, ten_seg;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   // One double-dabble step: add 3 to every nibble >= 5, then shift the
   // next magnitude bit (MSB first) into the BCD register.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 3; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      bcd_sh     = (bcd_adj << 1) | {11'd0, mag[n-1]};
      mag_sh     = mag << 1;
      last_shift = (cnt == CW'(n - 1));
   end

   // Decode straight from the final shift result so the new pattern is
   // registered on the edge into DONE, lining up with the done pulse.
   always_comb begin
      hun_seg = seg7(bcd_sh[11:8]);
      ten_seg = seg7(bcd_sh[7:4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (bcd_sh[11:8] == 4'd0) begin
         hun_seg = SEG_BLANK;
         if (bcd_sh[7:4] == 4'd0) begin
            ten_seg = SEG_BLANK;
         end
      end
`endif
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (force_cv || (display != last)) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            busy      = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_shift) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last       <= '0;
         force_cv   <= 1'b1;
         neg        <= 1'b0;
         mag        <= '0;
         bcd        <= '0;
         cnt        <= '0;
         digits     <= SEG_BLANK;
         ten_digits <= SEG_BLANK;
         hun_digits <= SEG_BLANK;
         sign       <= SEG_BLANK;
      end else begin
         state <= state_nxt;
         case (state)
            LOAD: begin
               last     <= display;
               neg      <= display[n-1];
               // Most negative input wraps to 2^(n-1), which is the correct
               // magnitude when read as unsigned.
               mag      <= display[n-1] ? (~display + {{(n-1){1'b0}}, 1'b1}) : display;
               bcd      <= '0;
               cnt      <= '0;
               force_cv <= 1'b0;
            end
            SHIFT: begin
               bcd <= bcd_sh;
               mag <= mag_sh;
               cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
               if (last_shift) begin
                  digits     <= seg7(bcd_sh[3:0]);
                  ten_digits <= ten_seg;
                  hun_digits <= hun_seg;
                  sign       <= neg ? SEG_MINUS : SEG_BLANK;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_display_bcd_driver.sv
// tb_display_bcd_driver: directed scenarios plus random values against an arithmetic display model.
// Latency: expects done exactly 10 cycles after a new value is presented to an idle driver.
// Backpressure: none; values changed mid-conversion must resolve to the latest one.

module tb_display_bcd_driver;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] display = 8'd0;
   logic [6:0] digits, ten_digits, hun_digits, sign;
   logic       busy, done;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0]  BLANK = 7'b1111111;
   localparam logic [6:0]  MINUS = 7'b0111111;
   localparam logic [27:0] ALL_BLANK = {4{BLANK}};

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   always #5 clk = ~clk;

   display_bcd_driver #(.n(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .display    (display),
      .digits     (digits),
      .ten_digits (ten_digits),
      .hun_digits (hun_digits),
      .sign       (sign),
      .busy       (busy),
      .done       (done)
   );

   wire [27:0] shown = {sign, hun_digits, ten_digits, digits};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected {sign, hundreds, tens, units} patterns from the decimal value.
   function automatic logic [27:0] model(input logic [7:0] v);
      int s, m, h, t, u;
      logic [6:0] sg, hs, ts;
      s  = $signed(v);
      m  = (s < 0) ? -s : s;
      h  = m / 100;
      t  = (m / 10) % 10;
      u  = m % 10;
      sg = (s < 0) ? MINUS : BLANK;
      hs = seg_tab[h];
      ts = seg_tab[t];
`ifdef LEADING_ZERO_BLANK_EN
      if (h == 0) hs = BLANK;
      if (h == 0 && t == 0) ts = BLANK;
`endif
      return {sg, hs, ts, seg_tab[u]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present v to an idle driver and check latency, busy length, output
   // stability during conversion and the final pattern.
   task automatic convert(input string tag, input logic [7:0] v, input logic [27:0] prev);
      int lat, busy_n;
      bit stable;
      lat = -1; busy_n = 0; stable = 1'b1;
      display = v;
      for (int i = 1; i <= 14; i++) begin
         tick();
         if (done) begin
            lat = i;
            break;
         end
         if (busy) busy_n++;
         if (shown !== prev) stable = 1'b0;
      end
      check({tag, "_latency"}, lat, 10);
      check({tag, "_busy_cycles"}, busy_n, 9);
      check({tag, "_stable"}, {31'd0, stable}, 1);
      check({tag, "_segments"}, shown, model(v));
      tick();
      check({tag, "_done_one_cycle"}, {31'd0, done}, 0);
   endtask

   initial begin
      logic [7:0] cur, v;
      int n_done, first_at, second_at;
      bit changed, busy_seen;
      logic [27:0] snap;

      // 1: reset then forced conversion of 0
      reset = 1'b1; display = 8'd0;
      tick();
      tick();
      check("reset_segments", shown, ALL_BLANK);
      check("reset_busy", {31'd0, busy}, 0);
      check("reset_done", {31'd0, done}, 0);
      reset = 1'b0;
      convert("after_reset", 8'd0, ALL_BLANK);
      cur = 8'd0;

      // 2, 3: positive, -1 and most negative
      convert("val_123", 8'd123, model(cur)); cur = 8'd123;
      convert("val_m1", 8'hFF, model(cur));   cur = 8'hFF;
      convert("val_m128", 8'h80, model(cur)); cur = 8'h80;

      // 4: change during SHIFT; both values must be shown, latest last
      snap = model(cur);
      display = 8'd45;
      n_done = 0; first_at = -1; second_at = -1; changed = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i == 4) display = 8'd67;
         if (done) begin
            n_done++;
            if (n_done == 1) begin
               first_at = i;
               check("mid_first_value", shown, model(8'd45));
            end else if (n_done == 2) begin
               second_at = i;
               check("mid_second_value", shown, model(8'd67));
            end
         end else if (i < 10 && shown !== snap) begin
            changed = 1'b1;
         end
      end
      check("mid_done_count", n_done, 2);
      check("mid_first_at", first_at, 10);
      check("mid_second_at", second_at, 21);
      check("mid_stable", {31'd0, changed}, 0);
      cur = 8'd67;

      // 5: reset aborts a conversion, then force reconverts the held value
      convert("val_99", 8'd99, model(cur)); cur = 8'd99;
      display = 8'd50;
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      tick();
      check("abort_blank", shown, ALL_BLANK);
      check("abort_busy", {31'd0, busy}, 0);
      tick();
      check("abort_blank_2", shown, ALL_BLANK);
      reset = 1'b0;
      n_done = 0; first_at = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (done) begin
            n_done++;
            if (n_done == 1) begin
               first_at = i;
               check("abort_value", shown, model(8'd50));
            end
         end
      end
      check("abort_done_count", n_done, 1);
      check("abort_latency", first_at, 10);
      cur = 8'd50;

      // 6: a held value never retriggers
      convert("val_7", 8'd7, model(cur)); cur = 8'd7;
      n_done = 0; busy_seen = 1'b0; changed = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (done) n_done++;
         if (busy) busy_seen = 1'b1;
         if (shown !== model(cur)) changed = 1'b1;
      end
      check("hold_done_count", n_done, 0);
      check("hold_busy", {31'd0, busy_seen}, 0);
      check("hold_stable", {31'd0, changed}, 0);

      // Random values; a repeat of the current value must not convert
      for (int k = 0; k < 30; k++) begin
         v = (k % 7 == 3) ? cur : 8'($urandom);
         if (v == cur) begin
            n_done = 0;
            display = v;
            for (int i = 0; i < 12; i++) begin
               tick();
               if (done || busy) n_done++;
            end
            check("rand_repeat_idle", n_done, 0);
            check("rand_repeat_segments", shown, model(cur));
         end else begin
            convert("rand", v, model(cur));
            cur = v;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
